// File: rtl/alu_rr_scheduler_pkg.sv
// Shared definitions for the two-requester ALU scheduler: opcode encodings,
// FSM state encoding and the legal-opcode check.
package alu_sched_pkg;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SRL = 6'b000010;
    localparam logic [5:0] OP_NOR = 6'b100111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic is_legal_op(input logic [5:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_SRA, OP_SRL, OP_NOR: is_legal_op = 1'b1;
            default:                        is_legal_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_rr_scheduler_arbiter.sv
// Two-input round-robin arbiter; purely combinational so any shared-resource
// block can pair it with its own last-grant register.
module rr_arbiter_2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic       grant_id,
    output logic       grant_valid
);

    always_comb begin
        grant_valid = |valid;
        grant_id    = 1'b0;
        if (valid == 2'b11)
            grant_id = ~last_grant;
        else if (valid[1])
            grant_id = 1'b1;
    end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Round-robin scheduler sharing one ALU between two valid/ready requesters.
// Optional macro ALU_SCHED_ILLEGAL_OP_CHECK_EN: reject illegal opcodes with rsp_err.
module alu_rr_scheduler #(
    parameter int NB_DATA = 8,
    parameter int NB_CODE = 6,
    parameter int ALU_LAT = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req0_valid,
    input  logic               req1_valid,
    output logic               req0_ready,
    output logic               req1_ready,
    input  logic [NB_DATA-1:0] req0_a,
    input  logic [NB_DATA-1:0] req0_b,
    input  logic [NB_DATA-1:0] req1_a,
    input  logic [NB_DATA-1:0] req1_b,
    input  logic [NB_CODE-1:0] req0_op,
    input  logic [NB_CODE-1:0] req1_op,
    output logic               rsp0_valid,
    output logic               rsp1_valid,
    input  logic               rsp0_ready,
    input  logic               rsp1_ready,
    output logic [NB_DATA-1:0] rsp0_data,
    output logic [NB_DATA-1:0] rsp1_data,
    output logic               rsp_err,
    output logic [NB_DATA-1:0] alu_a,
    output logic [NB_DATA-1:0] alu_b,
    output logic [NB_CODE-1:0] alu_op,
    input  logic [NB_DATA-1:0] alu_result,
    output logic               busy,
    output logic               grant_id
);

    import alu_sched_pkg::*;

    localparam logic [2:0] LAT = 3'(ALU_LAT);

    state_t             state, state_d;
    logic               last_grant;
    logic               grant_q;
    logic [NB_DATA-1:0] a_q, b_q, result_q;
    logic [NB_CODE-1:0] op_q;
    logic [2:0]         cnt;

    logic               arb_grant, arb_valid;
    logic               hs, op_ok, sel_rsp_ready;
    logic [NB_DATA-1:0] sel_a, sel_b;
    logic [NB_CODE-1:0] sel_op;

    rr_arbiter_2 u_arb (
        .valid       ({req1_valid, req0_valid}),
        .last_grant  (last_grant),
        .grant_id    (arb_grant),
        .grant_valid (arb_valid)
    );

    assign sel_a         = arb_grant ? req1_a  : req0_a;
    assign sel_b         = arb_grant ? req1_b  : req0_b;
    assign sel_op        = arb_grant ? req1_op : req0_op;
    assign sel_rsp_ready = grant_q ? rsp1_ready : rsp0_ready;

    always_comb begin
        state_d = state;
        hs      = 1'b0;
        op_ok   = 1'b1;
`ifdef ALU_SCHED_ILLEGAL_OP_CHECK_EN
        op_ok   = is_legal_op(6'(sel_op));
`endif
        case (state)
            IDLE: if (arb_valid) begin
                hs      = 1'b1;
                state_d = op_ok ? EXEC : RESP;
            end
            EXEC: if (cnt == LAT) state_d = RESP;
            RESP: if (sel_rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Ready is gated by rst_n so a handshake coinciding with reset is never seen as taken.
    assign req0_ready = rst_n && hs && !arb_grant;
    assign req1_ready = rst_n && hs &&  arb_grant;

`ifdef ALU_SCHED_ILLEGAL_OP_CHECK_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (!rst_n)
            err_q <= 1'b0;
        else if (state == IDLE && hs)
            err_q <= ~op_ok;
    end

    assign rsp_err = (state == RESP) && err_q;
`else
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            grant_q    <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            result_q   <= '0;
            cnt        <= '0;
        end else begin
            state <= state_d;
            case (state)
                IDLE: if (hs) begin
                    a_q     <= sel_a;
                    b_q     <= sel_b;
                    grant_q <= arb_grant;
                    cnt     <= '0;
                    if (op_ok)
                        op_q <= sel_op;
                    else
                        result_q <= '0;
                end
                EXEC: begin
                    cnt <= cnt + 3'd1;
                    if (cnt == LAT)
                        result_q <= alu_result;
                end
                RESP: if (sel_rsp_ready) last_grant <= grant_q;
                default: ;
            endcase
        end
    end

    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_op     = op_q;
    assign busy       = (state != IDLE);
    assign grant_id   = grant_q;
    assign rsp0_valid = (state == RESP) && !grant_q;
    assign rsp1_valid = (state == RESP) &&  grant_q;
    assign rsp0_data  = rsp0_valid ? result_q : '0;
    assign rsp1_data  = rsp1_valid ? result_q : '0;

endmodule

// File: doc/alu_rr_scheduler.md
Name: alu_rr_scheduler

Overview:
- Shares one ALU datapath (8-bit operands, 6-bit opcode: ADD, SUB, AND, OR, XOR, SRA, SRL, NOR) between two requesters.
- Each requester submits an (a, b, op) transaction over a valid/ready channel and receives the result on a separate valid/ready response channel.
- Arbitration is round-robin; one operation is in flight at a time.
- Sits between the switch/button input front-end (or a future UART front-end) and the ALU.

Parameters:
- NB_DATA, 8, operand and result width.
- NB_CODE, 6, opcode width.
- ALU_LAT, 0, ALU pipeline latency in cycles (0 = combinational ALU); legal range 0..7.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req0_valid / req1_valid  in  1  requester has a transaction.
- req0_ready / req1_ready  out  1  transaction accepted this cycle.
- req0_a, req0_b / req1_a, req1_b  in  NB_DATA  operands.
- req0_op / req1_op  in  NB_CODE  opcode.
- rsp0_valid / rsp1_valid  out  1  result available.
- rsp0_ready / rsp1_ready  in  1  requester takes result.
- rsp0_data / rsp1_data  out  NB_DATA  result.
- rsp_err  out  1  result flagged illegal opcode; qualified by the active rspN_valid.
- alu_a, alu_b  out  NB_DATA  operands to ALU.
- alu_op  out  NB_CODE  opcode to ALU.
- alu_result  in  NB_DATA  ALU output, valid ALU_LAT cycles after inputs are stable.
- busy  out  1  high whenever state != IDLE.
- grant_id  out  1  requester currently owning the ALU.

Behaviour:
- Reset (rst_n low at a clock edge, any state):
  - state=IDLE, last_grant=1 (so requester 0 wins first).
  - All outputs 0: readies, rsp valids, rsp data, rsp_err, alu_a, alu_b, alu_op, busy, grant_id.
  - Lat counter=0. An in-flight transaction is discarded and no response is issued.
- FSM IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - Grant is combinational from the valids and last_grant.
    - Both valid: grant the requester != last_grant.
    - One valid: grant it.
  - reqN_ready = (state==IDLE) && granted && reqN_valid. Never assert both readies.
  - On the handshake, register a, b, op and grant_id; clear the counter; go to EXEC.
  - A requester dropping valid before ready is legal and has no effect.
- EXEC:
  - alu_a, alu_b, alu_op are driven from the registers and held stable for the whole state.
  - The counter increments each cycle.
  - When counter==ALU_LAT, capture alu_result into the result register and go to RESP.
  - With ALU_LAT=0, EXEC lasts exactly one cycle.
- RESP:
  - rsp[grant_id]_valid=1, rsp[grant_id]_data=result. The other rsp valid stays 0.
  - Held until rsp[grant_id]_ready is high at a clock edge.
  - Then: last_grant<=grant_id, valid drops next cycle, go to IDLE.
  - New requests are not accepted during RESP.
- Timing:
  - Minimum occupancy is 3+ALU_LAT cycles per transaction.
  - Request handshake to rsp_valid = 1+ALU_LAT+1 edges.
- Fairness: with both requesters continuously valid, grants strictly alternate 0,1,0,1.
- Width: result is NB_DATA bits, truncated (carry/borrow dropped). The scheduler never alters operand values.
- rst_n asserted on the same edge as a handshake: reset wins, and ready is treated as not taken.

Optional Feature:
- Macro ALU_SCHED_ILLEGAL_OP_CHECK_EN.
- Defined:
  - In IDLE, the opcode is checked against the 8 legal codes.
  - An illegal opcode skips EXEC and goes IDLE->RESP with data=0 and rsp_err=1.
  - alu_op is not updated for that transaction.
- Undefined: every opcode goes through EXEC, and rsp_err is tied to 0.

Decomposition:
- Package alu_sched_pkg holds:
  - the opcode localparams ADD=100000, SUB=100010, AND=100100, OR=100101, XOR=100110, SRA=000011, SRL=000010, NOR=100111;
  - the FSM state encoding (IDLE=2'd0, EXEC=2'd1, RESP=2'd2);
  - the legal-op check function.
- Sub-module rr_arbiter_2: 2-input round-robin grant from valids and last_grant. Purely combinational, reusable by future shared-resource blocks.

Test Plan:
- Req0 a=0x10, b=0x07, op=ADD, ALU_LAT=0 -> rsp0_valid 2 edges after handshake, data=0x17, rsp1_valid stays 0.
- Req0 and req1 both valid (req0 SUB 0x10,0x07; req1 AND 0x10,0x07), both rsp_ready=1:
  - rsp0 data=0x09 first, then rsp1 data=0x00;
  - grant order 0,1,0,1 over 4 back-to-back transactions.
- rsp1_ready held low 5 cycles after rsp1_valid (op OR 0x10,0x07):
  - rsp1_valid and data=0x17 stay stable for all 5 cycles;
  - req0_ready stays 0;
  - ALU inputs are unchanged.
- ALU_LAT=3, op SRL a=0x10, b=0x02:
  - alu_* held stable 4 cycles;
  - rsp data=0x04;
  - busy high for 5 cycles.
- rst_n pulled low mid-EXEC -> next cycle all outputs 0 and state IDLE, no response issued; req1 is then granted first, because last_grant was reset to 1 and it is the only valid.
- With macro, op=111111 -> RESP directly, data=0x00, rsp_err=1. Without macro -> passes through EXEC and rsp_err=0.
